// File: rtl/universal_sreg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : universal_sreg_pkg
// Purpose  : Shared mode encoding for the universal shift register.
// Revision : 1.0 - initial release
// ============================================================================
package universal_sreg_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD = 2'b00;
  localparam mode_t MODE_SHR  = 2'b01;
  localparam mode_t MODE_SHL  = 2'b10;
  localparam mode_t MODE_LOAD = 2'b11;

endpackage : universal_sreg_pkg
`default_nettype wire

// File: rtl/universal_sreg_if.sv
`default_nettype none
// ============================================================================
// Module   : universal_sreg_if
// Purpose  : Data/mode bus of the universal shift register. The master
//            drives parallel data and mode; the slave returns the contents.
// Revision : 1.0 - initial release
// ============================================================================
interface universal_sreg_if #(
  parameter int WIDTH = 4
);
  import universal_sreg_pkg::*;

  logic [WIDTH-1:0] in;
  mode_t            sel;
  logic [WIDTH-1:0] out;

  modport master (output in, output sel, input out);
  modport slave  (input in, input sel, output out);

endinterface : universal_sreg_if
`default_nettype wire

// File: rtl/universal_sreg_next.sv
`default_nettype none
// ============================================================================
// Module   : universal_sreg_next
// Purpose  : Combinational next-state mux: hold, shift right, shift left,
//            parallel load. Unknown or unlisted mode codes fall back to hold.
// Revision : 1.0 - initial release
// ============================================================================
module universal_sreg_next
  import universal_sreg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  wire logic [WIDTH-1:0] cur_i,
  input  wire logic [WIDTH-1:0] in_i,
  input  wire mode_t            sel_i,
  output logic      [WIDTH-1:0] nxt_o
);

  logic [WIDTH-1:0] shr_w;
  logic [WIDTH-1:0] shl_w;

  // A one-bit register has nothing to shift, so both directions just take
  // the serial-in bit; wider registers drop the bit at the far end.
  if (WIDTH == 1) begin : g_w1
    assign shr_w = in_i[0];
    assign shl_w = in_i[0];
  end else begin : g_wn
    assign shr_w = {in_i[WIDTH-1], cur_i[WIDTH-1:1]};
    assign shl_w = {cur_i[WIDTH-2:0], in_i[0]};
  end

  // Mode select; any unresolved code keeps the current value.
  always_comb begin
    nxt_o = cur_i;
    case (sel_i)
      MODE_HOLD: nxt_o = cur_i;
      MODE_SHR:  nxt_o = shr_w;
      MODE_SHL:  nxt_o = shl_w;
      MODE_LOAD: nxt_o = in_i;
      default:   nxt_o = cur_i;
    endcase
  end

endmodule : universal_sreg_next
`default_nettype wire

// File: rtl/universal_sreg.sv
`default_nettype none
// ============================================================================
// Module   : universal_sreg
// Purpose  : N-bit universal shift register. Flop bank with asynchronous
//            active-low clear; output is taken straight from the flops.
// Revision : 1.0 - initial release
// ============================================================================
module universal_sreg
  import universal_sreg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  wire logic        clk,
  input  wire logic        clr,
  universal_sreg_if.slave  bus
);

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] in_w;
  mode_t            sel_w;

  assign in_w  = bus.in;
  assign sel_w = bus.sel;

  universal_sreg_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .cur_i (out_q),
    .in_i  (in_w),
    .sel_i (sel_w),
    .nxt_o (out_d)
  );

  // Register bank; clear acts immediately and dominates a coincident edge.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign bus.out = out_q;

  // An unresolved mode while running is held, but it is still worth flagging.
  a_sel_known : assert property (@(posedge clk) disable iff (!clr)
                                 !$isunknown(sel_w))
    else $error("universal_sreg: sel is unknown while clr is released");

endmodule : universal_sreg
`default_nettype wire

// File: tb/tb_universal_sreg.sv
`default_nettype none
// ============================================================================
// Module   : tb_universal_sreg
// Purpose  : Directed self-checking bench for universal_sreg (WIDTH 4 and 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_universal_sreg;

  logic clk;
  logic clr;
  int   n_checks;
  int   n_errors;

  universal_sreg_if #(.WIDTH(4)) bus  ();
  universal_sreg_if #(.WIDTH(1)) bus1 ();

  universal_sreg #(.WIDTH(4)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  universal_sreg #(.WIDTH(1)) dut1 (
    .clk (clk),
    .clr (clr),
    .bus (bus1)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Reset held across two edges with an unresolved mode.
    clr      = 1'b0;
    bus.sel  = 2'bxx;
    bus.in   = 4'b1011;
    bus1.sel = 2'b11;
    bus1.in  = 1'b1;
    #1;
    check("reset_t0", bus.out, 4'b0000);
    check("reset1_t0", {3'b000, bus1.out}, 4'b0000);
    tick();
    check("reset_e1", bus.out, 4'b0000);
    tick();
    check("reset_e2", bus.out, 4'b0000);
    check("reset1_e2", {3'b000, bus1.out}, 4'b0000);

    // Release clear, then shift right with serial-in in[3]=1.
    bus1.sel = 2'b00;
    clr      = 1'b1;
    bus.sel  = 2'b01;
    bus.in   = 4'b1011;
    tick();
    check("shr_1", bus.out, 4'b1000);
    tick();
    check("shr_2", bus.out, 4'b1100);

    // Re-establish 1000, then shift left with serial-in in[0].
    bus.sel = 2'b11;
    bus.in  = 4'b1000;
    tick();
    check("load_1000", bus.out, 4'b1000);
    bus.sel = 2'b10;
    bus.in  = 4'b1011;
    tick();
    check("shl_1", bus.out, 4'b0001);
    bus.in  = 4'b1010;
    tick();
    check("shl_2", bus.out, 4'b0010);

    // Parallel load then hold for three edges with different input data.
    bus.sel = 2'b11;
    bus.in  = 4'b1011;
    tick();
    check("load_1011", bus.out, 4'b1011);
    bus.sel = 2'b00;
    bus.in  = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold", bus.out, 4'b1011);
    end

    // Clear pulled low inside the high phase; must act before the next edge.
    @(posedge clk);
    #2;
    clr = 1'b0;
    #1;
    check("async_clr", bus.out, 4'b0000);
    bus.sel = 2'b11;
    bus.in  = 4'b0110;
    tick();
    check("clr_held_load", bus.out, 4'b0000);
    clr = 1'b1;
    tick();
    check("load_after_clr", bus.out, 4'b0110);

    // Full shift-through from zero with serial-in 1, then a 0.
    bus.sel = 2'b11;
    bus.in  = 4'b0000;
    tick();
    check("load_0000", bus.out, 4'b0000);
    bus.sel = 2'b10;
    bus.in  = 4'b0001;
    tick();
    check("thru_1", bus.out, 4'b0001);
    tick();
    check("thru_2", bus.out, 4'b0011);
    tick();
    check("thru_3", bus.out, 4'b0111);
    tick();
    check("thru_4", bus.out, 4'b1111);
    bus.in  = 4'b0000;
    tick();
    check("thru_5", bus.out, 4'b1110);

    // Shift right with serial-in in[3]=0 (in[0]=1 must not leak in).
    bus.sel = 2'b01;
    bus.in  = 4'b0111;
    tick();
    check("shr_zero_in", bus.out, 4'b0111);

    // One-bit register: load, hold, both shift directions take in[0].
    bus.sel  = 2'b00;
    bus1.sel = 2'b11;
    bus1.in  = 1'b1;
    tick();
    check("w1_load", {3'b000, bus1.out}, 4'b0001);
    bus1.sel = 2'b00;
    bus1.in  = 1'b0;
    tick();
    check("w1_hold", {3'b000, bus1.out}, 4'b0001);
    bus1.sel = 2'b01;
    tick();
    check("w1_shr", {3'b000, bus1.out}, 4'b0000);
    bus1.sel = 2'b10;
    bus1.in  = 1'b1;
    tick();
    check("w1_shl", {3'b000, bus1.out}, 4'b0001);
    check("hold_final", bus.out, 4'b0111);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_universal_sreg
`default_nettype wire
